seq_booth_r4_multiplier: RTL and testbench

Iterative radix-4 Booth multiplier, parametrised in operand width, with runtime signed/unsigned mode. It replaces the fixed 32-bit single-shot multiplier plus divided write clock with a single-clock datapath. It uses valid/ready handshakes on both input and output, so it drops into any streaming arithmetic pipeline. It retires one Booth digit per cycle using one adder, trading latency for area.

---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_r4_encoder.sv | 23 ++
 rtl/seq_booth_r4_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_booth_r4_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
// Contents: FSM state enum, Booth digit struct with its five encodings,
//           and the digit-count helper.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One recoded Booth digit: magnitude is 0, 1 or 2, and neg gives the sign.
   typedef struct packed {
      logic neg;
      logic zero;
      logic two;
   } booth_digit_t;

   localparam booth_digit_t DIG_ZERO = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
   localparam booth_digit_t DIG_P1   = '{neg: 1'b0, zero: 1'b0, two: 1'b0};
   localparam booth_digit_t DIG_P2   = '{neg: 1'b0, zero: 1'b0, two: 1'b1};
   localparam booth_digit_t DIG_M1   = '{neg: 1'b1, zero: 1'b0, two: 1'b0};
   localparam booth_digit_t DIG_M2   = '{neg: 1'b1, zero: 1'b0, two: 1'b1};

   // The operands are extended by two bits so the top digit of an unsigned
   // operand is never negative. That extension gives width/2+1 digits.
   function automatic int booth_iter(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the window {y[2i+1], y[2i], y[2i-1]} to a digit.
// Ports: i_win (3-bit multiplier window), o_digit ({neg, zero, two}).
// Purely combinational, with no latency and no flow control.
module booth_r4_encoder
   import booth_pkg::*;
(
   input  logic [2:0]   i_win,
   output booth_digit_t o_digit
);

   always_comb begin
      o_digit = DIG_ZERO;
      case (i_win)
         3'b000, 3'b111: o_digit = DIG_ZERO;
         3'b001, 3'b010: o_digit = DIG_P1;
         3'b011:         o_digit = DIG_P2;
         3'b100:         o_digit = DIG_M2;
         3'b101, 3'b110: o_digit = DIG_M1;
         default:        o_digit = DIG_ZERO;
      endcase
   end

endmodule

// File: rtl/seq_booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier that retires one digit per cycle, with signed and unsigned modes.
// Ports: in_valid/in_ready/in_signed/x/y (operand handshake), out_valid/out_ready/product
//        (result handshake, held while out_valid), busy. Latency is WIDTH/2+1 edges after accept.
module seq_booth_r4_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int ITER  = booth_iter(WIDTH);
   localparam int ACC_W = 2 * WIDTH + 4;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   state_t               r_state;
   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     r_x;      // multiplicand, pre-shifted by 2i
   logic [WIDTH+1:0]     r_y;      // multiplier, shifted right by 2 per digit
   logic                 r_yprev;  // y[2i-1] for the current window
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;
   logic [2*WIDTH-1:0]   r_product;

   booth_digit_t         w_digit;
   logic                 w_xs;
   logic                 w_ys;
   logic [ACC_W-1:0]     w_x_ext;
   logic [WIDTH+1:0]     w_y_ext;
   logic [ACC_W-1:0]     w_mag;
   logic [ACC_W-1:0]     w_pp;
   logic [ACC_W-1:0]     w_acc_nxt;

   booth_r4_encoder u_enc (
      .i_win   ({r_y[1], r_y[0], r_yprev}),
      .o_digit (w_digit)
   );

   always_comb begin
      w_xs    = in_signed & x[WIDTH-1];
      w_ys    = in_signed & y[WIDTH-1];
      w_x_ext = {{(WIDTH + 4){w_xs}}, x};
      w_y_ext = {{2{w_ys}}, y};
      w_mag   = w_digit.zero ? '0 :
                (w_digit.two ? {r_x[ACC_W-2:0], 1'b0} : r_x);
      // Wrap-around arithmetic modulo 2^ACC_W: the low 2*WIDTH bits come out exact.
      w_pp      = w_digit.neg ? (~w_mag + ACC_W'(1)) : w_mag;
      w_acc_nxt = r_acc + w_pp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_yprev     <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_x        <= w_x_ext;
                  r_y        <= w_y_ext;
                  r_yprev    <= 1'b0;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_acc   <= w_acc_nxt;
               r_x     <= {r_x[ACC_W-3:0], 2'b00};
               r_y     <= {2'b00, r_y[WIDTH+1:2]};
               r_yprev <= r_y[1];
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_product   <= w_acc_nxt[2*WIDTH-1:0];
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign product   = r_product;

endmodule

// File: tb/tb_seq_booth_r4_multiplier.sv
// Testbench for seq_booth_r4_multiplier: WIDTH=32 and WIDTH=8 instances share the clock and reset.
// Table vectors and hand sequences (backpressure, mid-operation reset) go through a scoreboard queue.
// Outputs are sampled 1ns after the rising edge. Inputs are driven at the same point.
module tb_seq_booth_r4_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid32 = 1'b0, in_signed32 = 1'b0, out_ready32 = 1'b1;
   logic [31:0] x32 = '0, y32 = '0;
   logic        in_ready32, out_valid32, busy32;
   logic [63:0] product32;

   logic        in_valid8 = 1'b0, in_signed8 = 1'b0, out_ready8 = 1'b1;
   logic [7:0]  x8 = '0, y8 = '0;
   logic        in_ready8, out_valid8, busy8;
   logic [15:0] product8;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] q32[$];
   logic [15:0] q8[$];

   always #5 clk = ~clk;

   seq_booth_r4_multiplier #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_signed(in_signed32),
      .x(x32), .y(y32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .product(product32), .busy(busy32)
   );

   seq_booth_r4_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
      .x(x8), .y(y8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .busy(busy8)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'b0, a};
      eb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] ea, eb;
      ea = s ? {{8{a[7]}}, a} : {8'b0, a};
      eb = s ? {{8{b[7]}}, b} : {8'b0, b};
      return ea * eb;
   endfunction

   // Run one WIDTH=32 operation. Returns with out_valid high when do_hs=0.
   task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string nm, input bit do_hs);
      int  n;
      bit  got;
      logic [63:0] e;
      n = 0;
      while (!in_ready32 && n < 50) begin @(posedge clk); #1; n++; end
      check({nm, "_rdy"}, 64'(in_ready32), 64'd1);
      in_valid32 = 1'b1; in_signed32 = s; x32 = a; y32 = b;
      @(posedge clk); #1;
      q32.push_back(exp);
      // Scramble inputs while busy: they must not affect the result.
      in_valid32 = 1'b0; in_signed32 = ~s; x32 = $urandom; y32 = $urandom;
      check({nm, "_busy"}, {62'd0, busy32, in_ready32}, 64'd2);
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(posedge clk); #1; n++;
         if (out_valid32) got = 1;
      end
      check({nm, "_lat"}, 64'(n), 64'd17);
      if (got) begin
         if (q32.size() == 0) check({nm, "_sbempty"}, 64'd0, 64'd1);
         else begin
            e = q32.pop_front();
            check({nm, "_prod"}, product32, e);
         end
         if (do_hs) begin
            @(posedge clk); #1;
            check({nm, "_post"}, {61'd0, out_valid32, in_ready32, busy32}, 64'd2);
         end
      end
   endtask

   task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b);
      int  n;
      bit  got;
      logic [15:0] e;
      n = 0;
      while (!in_ready8 && n < 20) begin @(posedge clk); #1; n++; end
      in_valid8 = 1'b1; in_signed8 = s; x8 = a; y8 = b;
      @(posedge clk); #1;
      q8.push_back(ref8(s, a, b));
      in_valid8 = 1'b0; in_signed8 = ~s; x8 = 8'($urandom); y8 = 8'($urandom);
      n = 0; got = 0;
      while (n < 20 && !got) begin
         @(posedge clk); #1; n++;
         if (out_valid8) got = 1;
      end
      check("w8_lat", 64'(n), 64'd5);
      if (got && q8.size() != 0) begin
         e = q8.pop_front();
         check($sformatf("w8_prod s=%0d %h*%h", s, a, b), 64'(product8), 64'(e));
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vt[10];
   logic [7:0] corners[8];

   initial begin
      logic [63:0] held;
      bit          saw;
      logic [31:0] ra, rb;

      vt[0] = '{1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
      vt[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vt[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
      vt[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vt[4] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
      vt[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vt[6] = '{1'b0, 32'd0,         32'hDEAD_BEEF, 64'd0};
      vt[7] = '{1'b1, 32'd1,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      ra = $urandom; rb = $urandom;
      vt[8] = '{1'b0, ra, rb, ref32(1'b0, ra, rb)};
      ra = $urandom; rb = $urandom;
      vt[9] = '{1'b1, ra, rb, ref32(1'b1, ra, rb)};

      corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h55, 8'hAA};

      // Reset state
      @(posedge clk); #1;
      check("rst_in_ready", 64'(in_ready32), 64'd1);
      check("rst_out_valid", 64'(out_valid32), 64'd0);
      check("rst_busy", 64'(busy32), 64'd0);
      check("rst_product", product32, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         op32(vt[i].s, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i), 1'b1);

      // Backpressure: result held and new requests refused while DONE.
      out_ready32 = 1'b0;
      op32(1'b1, 32'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FD44, "bp", 1'b0);
      held = product32;
      for (int c = 0; c < 10; c++) begin
         in_valid32 = 1'b1; in_signed32 = 1'b0; x32 = 32'd3; y32 = 32'd3;
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d", c), {product32[61:0], out_valid32, in_ready32},
               {held[61:0], 1'b1, 1'b0});
      end
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {61'd0, out_valid32, in_ready32, busy32}, 64'd2);
      check("bp_prod_kept", product32, held);
      op32(1'b0, 32'd12345, 32'd678, 64'd8369910, "bp_after", 1'b1);

      // Reset asserted between edges, five cycles after accept.
      in_valid32 = 1'b1; in_signed32 = 1'b0; x32 = 32'd1000; y32 = 32'd1000;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {61'd0, out_valid32, in_ready32, busy32}, 64'd2);
      check("mid_rst_product", product32, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid32) saw = 1;
      end
      check("mid_rst_no_pulse", 64'(saw), 64'd0);
      op32(1'b0, 32'd7, 32'd6, 64'd42, "after_rst", 1'b1);

      // WIDTH=8: corner cross product in both modes, then random pairs.
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               op8(s[0], corners[i], corners[j]);
      for (int k = 0; k < 256; k++)
         op8(k[0], 8'($urandom), 8'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
